// File: rtl/ibex_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ibex_mem_arbiter
//
// Shares one downstream req/gnt/rvalid memory port among NUM_HOSTS requesters.
// Arbitration is round-robin. Once a host is presented to memory, it is locked
// in until the grant arrives, so the downstream request stays stable across a
// stall. An in-order FIFO of granted host IDs routes each response back to
// the host that issued the request.
//
// Ports
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_host_req / o_host_gnt           per-host request / zero-latency grant
//   i_host_addr/we/be/wdata/wintg     packed per-host request fields, host 0 in LSBs
//   o_host_rvalid                     per-host response valid
//   o_host_rdata/rintg/error          shared response fields, qualified by o_host_rvalid
//   o_mem_req, i_mem_gnt              downstream request handshake
//   o_mem_addr/we/be/wdata/wintg      selected host's fields (zero when idle)
//   i_mem_rvalid/rdata/rintg/error    downstream response
//   o_outstanding                     granted-but-unanswered transaction count
//   o_err_spurious                    sticky: response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ibex_mem_arbiter #(
    parameter int NUM_HOSTS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INTG_WIDTH      = 7,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_WIDTH       = DATA_WIDTH / 8,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,

    input  logic [NUM_HOSTS-1:0]            i_host_req,
    output logic [NUM_HOSTS-1:0]            o_host_gnt,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0] i_host_addr,
    input  logic [NUM_HOSTS-1:0]            i_host_we,
    input  logic [NUM_HOSTS*BE_WIDTH-1:0]   i_host_be,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0] i_host_wdata,
    input  logic [NUM_HOSTS*INTG_WIDTH-1:0] i_host_wintg,
    output logic [NUM_HOSTS-1:0]            o_host_rvalid,
    output logic [DATA_WIDTH-1:0]           o_host_rdata,
    output logic [INTG_WIDTH-1:0]           o_host_rintg,
    output logic                            o_host_error,

    output logic                            o_mem_req,
    input  logic                            i_mem_gnt,
    output logic [ADDR_WIDTH-1:0]           o_mem_addr,
    output logic                            o_mem_we,
    output logic [BE_WIDTH-1:0]             o_mem_be,
    output logic [DATA_WIDTH-1:0]           o_mem_wdata,
    output logic [INTG_WIDTH-1:0]           o_mem_wintg,
    input  logic                            i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
    input  logic [INTG_WIDTH-1:0]           i_mem_rintg,
    input  logic                            i_mem_error,

    output logic [CNT_WIDTH-1:0]            o_outstanding,
    output logic                            o_err_spurious
);

    localparam int ID_WIDTH  = $clog2(NUM_HOSTS);
    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [ID_WIDTH-1:0]  LAST_HOST  = ID_WIDTH'(NUM_HOSTS - 1);
    localparam logic [PTR_WIDTH-1:0] LAST_SLOT  = PTR_WIDTH'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(MAX_OUTSTANDING);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ID_WIDTH-1:0]  r_rr_ptr;
    logic                 r_locked;
    logic [ID_WIDTH-1:0]  r_lock_id;
    logic [ID_WIDTH-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_err_spurious;

    // -----------------------------------------------------------------------
    // Unpack the per-host request fields into arrays indexed by host ID
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_addr  [NUM_HOSTS];
    logic [BE_WIDTH-1:0]   w_be    [NUM_HOSTS];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_HOSTS];
    logic [INTG_WIDTH-1:0] w_wintg [NUM_HOSTS];

    for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_unpack
        assign w_addr[g]  = i_host_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_be[g]    = i_host_be[g*BE_WIDTH +: BE_WIDTH];
        assign w_wdata[g] = i_host_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_wintg[g] = i_host_wintg[g*INTG_WIDTH +: INTG_WIDTH];
    end

    // -----------------------------------------------------------------------
    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    // -----------------------------------------------------------------------
    logic [ID_WIDTH-1:0] w_idx;
    logic [ID_WIDTH-1:0] w_rr_sel;
    logic                w_rr_found;

    // NOTE: every variable driven here gets a default before the loop; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_idx      = r_rr_ptr;
        w_rr_sel   = r_rr_ptr;
        w_rr_found = 1'b0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (!w_rr_found && i_host_req[w_idx]) begin
                w_rr_sel   = w_idx;
                w_rr_found = 1'b1;
            end
            w_idx = (w_idx == LAST_HOST) ? '0 : w_idx + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Request path (zero latency)
    // -----------------------------------------------------------------------
    logic [ID_WIDTH-1:0] w_sel;
    logic                w_full;
    logic                w_empty;
    logic                w_grant;
    logic                w_pop;
    logic [ID_WIDTH-1:0] w_head;

    // A stalled host keeps the port until granted, even if the rotation has
    // since moved on to a higher-priority requester.
    assign w_sel   = r_locked ? r_lock_id : w_rr_sel;
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    assign o_mem_req = (|i_host_req) && !w_full;
    assign w_grant   = o_mem_req && i_mem_gnt;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        o_mem_wdata = '0;
        o_mem_wintg = '0;
        o_host_gnt  = '0;
        if (o_mem_req) begin
            o_mem_addr  = w_addr[w_sel];
            o_mem_we    = i_host_we[w_sel];
            o_mem_be    = w_be[w_sel];
            o_mem_wdata = w_wdata[w_sel];
            o_mem_wintg = w_wintg[w_sel];
        end
        if (w_grant) begin
            o_host_gnt[w_sel] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Response path (zero latency). Emptiness is judged before this cycle's
    // push, so a response coinciding with the first grant is still spurious.
    // -----------------------------------------------------------------------
    assign w_pop  = i_mem_rvalid && !w_empty;
    assign w_head = r_fifo[r_rd_ptr];

    always_comb begin
        o_host_rvalid = '0;
        if (w_pop) begin
            o_host_rvalid[w_head] = 1'b1;
        end
    end

    assign o_host_rdata   = i_mem_rdata;
    assign o_host_rintg   = i_mem_rintg;
    assign o_host_error   = i_mem_error;
    assign o_outstanding  = r_count;
    assign o_err_spurious = r_err_spurious;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr       <= '0;
            r_locked       <= 1'b0;
            r_lock_id      <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_sel == LAST_HOST) ? '0 : w_sel + 1'b1;
                r_locked <= 1'b0;
                r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
            end else if (o_mem_req) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_sel;
            end

            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
            end

            // Grant is impossible while full, so a push never overflows.
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (i_mem_rvalid && w_empty) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    // NOTE: the ID storage has no reset; only slots between the read and write
    // pointers are ever read, and those pointers are reset.
    always_ff @(posedge i_clk) begin
        if (w_grant) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ibex_mem_arbiter
//
// Directed scenarios with hand-computed expectations, followed by a random
// phase. A behavioural model (rotation pointer, locked host, queue of
// outstanding host IDs, sticky error flag) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ibex_mem_arbiter;

    localparam int NH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 7;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [NH-1:0]     host_req;
    logic [NH-1:0]     host_gnt;
    logic [NH*AW-1:0]  host_addr;
    logic [NH-1:0]     host_we;
    logic [NH*BW-1:0]  host_be;
    logic [NH*DW-1:0]  host_wdata;
    logic [NH*IW-1:0]  host_wintg;
    logic [NH-1:0]     host_rvalid;
    logic [DW-1:0]     host_rdata;
    logic [IW-1:0]     host_rintg;
    logic              host_error;
    logic              mem_req;
    logic              mem_gnt;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [BW-1:0]     mem_be;
    logic [DW-1:0]     mem_wdata;
    logic [IW-1:0]     mem_wintg;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic [IW-1:0]     mem_rintg;
    logic              mem_error;
    logic [CW-1:0]     outstanding;
    logic              err_spurious;

    ibex_mem_arbiter #(
        .NUM_HOSTS       (NH),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .INTG_WIDTH      (IW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_host_req     (host_req),
        .o_host_gnt     (host_gnt),
        .i_host_addr    (host_addr),
        .i_host_we      (host_we),
        .i_host_be      (host_be),
        .i_host_wdata   (host_wdata),
        .i_host_wintg   (host_wintg),
        .o_host_rvalid  (host_rvalid),
        .o_host_rdata   (host_rdata),
        .o_host_rintg   (host_rintg),
        .o_host_error   (host_error),
        .o_mem_req      (mem_req),
        .i_mem_gnt      (mem_gnt),
        .o_mem_addr     (mem_addr),
        .o_mem_we       (mem_we),
        .o_mem_be       (mem_be),
        .o_mem_wdata    (mem_wdata),
        .o_mem_wintg    (mem_wintg),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .i_mem_rintg    (mem_rintg),
        .i_mem_error    (mem_error),
        .o_outstanding  (outstanding),
        .o_err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int m_rr    = 0;
    int m_lock  = -1;
    int m_q[$];
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    // Compare on the falling edge (inputs stable, away from the active edge),
    // then advance the model to the state the next rising edge will produce.
    always @(negedge clk) begin : compare
        int            sel;
        bit            found;
        bit            exp_req;
        bit            grant;
        bit            pop;
        logic [NH-1:0] exp_gnt;
        logic [NH-1:0] exp_rv;
        if (m_valid) begin
            if (m_lock >= 0) begin
                sel = m_lock;
            end else begin
                sel   = m_rr;
                found = 1'b0;
                for (int k = 0; k < NH; k++) begin
                    if (!found && host_req[(m_rr + k) % NH]) begin
                        sel   = (m_rr + k) % NH;
                        found = 1'b1;
                    end
                end
            end
            exp_req = (host_req != '0) && (m_q.size() < MO);
            grant   = exp_req && mem_gnt;
            pop     = mem_rvalid && (m_q.size() > 0);
            exp_gnt = '0;
            if (grant) exp_gnt[sel] = 1'b1;
            exp_rv = '0;
            if (pop) exp_rv[m_q[0]] = 1'b1;

            check("mem_req", mem_req, exp_req);
            check("mem_addr", mem_addr, exp_req ? host_addr[sel*AW +: AW] : '0);
            check("mem_we", mem_we, exp_req ? host_we[sel] : 1'b0);
            check("mem_be", mem_be, exp_req ? host_be[sel*BW +: BW] : '0);
            check("mem_wdata", mem_wdata, exp_req ? host_wdata[sel*DW +: DW] : '0);
            check("mem_wintg", mem_wintg, exp_req ? host_wintg[sel*IW +: IW] : '0);
            check("host_gnt", host_gnt, exp_gnt);
            check("host_rvalid", host_rvalid, exp_rv);
            check("host_rdata", host_rdata, mem_rdata);
            check("host_rintg", host_rintg, mem_rintg);
            check("host_error", host_error, mem_error);
            check("outstanding", outstanding, m_q.size());
            check("err_spurious", err_spurious, m_err);

            if (!reset) begin
                if (mem_rvalid && m_q.size() == 0) m_err = 1'b1;
                if (pop) void'(m_q.pop_front());
                if (grant) begin
                    m_q.push_back(sel);
                    m_rr   = (sel + 1) % NH;
                    m_lock = -1;
                end else if (exp_req) begin
                    m_lock = sel;
                end
            end
        end
        if (reset) begin
            m_q.delete();
            m_rr    = 0;
            m_lock  = -1;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_req   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        host_req   = '0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
        host_wintg = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rintg  = '0;
        mem_error  = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst outstanding", outstanding, 0);
        check("rst err_spurious", err_spurious, 0);
        check("rst mem_req", mem_req, 0);
        check("rst host_gnt", host_gnt, 0);

        // Single host 0 read, granted immediately, answered two cycles later.
        host_addr[0 +: AW] = 32'h0000_1000;
        host_req = 2'b01;
        mem_gnt  = 1'b1;
        #1;
        check("t1 host_gnt", host_gnt, 2'b01);
        check("t1 mem_addr", mem_addr, 32'h0000_1000);
        check("t1 outstanding0", outstanding, 0);
        step();
        idle_inputs();
        #1;
        check("t1 outstanding1", outstanding, 1);
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("t1 host_rvalid", host_rvalid, 2'b01);
        check("t1 host_rdata", host_rdata, 32'hDEAD_BEEF);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("t1 outstanding2", outstanding, 0);

        // Both hosts streaming: alternate grants, fill to the limit, then drain.
        reset = 1'b1;
        step();
        reset = 1'b0;
        host_addr = {32'h0000_0200, 32'h0000_0100};
        host_req  = 2'b11;
        mem_gnt   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2 alt grant", host_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        #1;
        check("t2 full mem_req", mem_req, 0);
        check("t2 full count", outstanding, 4);
        step();
        mem_rvalid = 1'b1;
        #1;
        check("t2 pop while full mem_req", mem_req, 0);
        check("t2 first response", host_rvalid, 2'b01);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("t2 mem_req reassert", mem_req, 1);
        check("t2 regrant host0", host_gnt, 2'b01);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            #1;
            check("t2 drain order", host_rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        mem_rvalid = 1'b0;
        #1;
        check("t2 drained", outstanding, 0);

        // Stalled host 1 keeps the port even though host 0 joins with priority.
        reset = 1'b1;
        step();
        reset = 1'b0;
        host_addr = {32'h0000_B000, 32'h0000_A000};
        host_req  = 2'b10;
        mem_gnt   = 1'b0;
        #1;
        check("t3 stall addr c1", mem_addr, 32'h0000_B000);
        step();
        host_req = 2'b11;
        #1;
        check("t3 stall addr c2", mem_addr, 32'h0000_B000);
        check("t3 no grant c2", host_gnt, 2'b00);
        step();
        #1;
        check("t3 stall addr c3", mem_addr, 32'h0000_B000);
        step();
        mem_gnt = 1'b1;
        #1;
        check("t3 host1 first", host_gnt, 2'b10);
        step();
        #1;
        check("t3 host0 next", host_gnt, 2'b01);
        check("t3 host0 addr", mem_addr, 32'h0000_A000);
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        #1;
        check("t3 resp host1", host_rvalid, 2'b10);
        step();
        #1;
        check("t3 resp host0", host_rvalid, 2'b01);
        step();
        mem_rvalid = 1'b0;

        // Spurious response with nothing outstanding.
        mem_rvalid = 1'b1;
        #1;
        check("t4 no host_rvalid", host_rvalid, 2'b00);
        check("t4 err before", err_spurious, 0);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("t4 err set", err_spurious, 1);
        repeat (3) step();
        check("t4 err sticky", err_spurious, 1);

        // Reset with two transactions in flight discards them.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        host_req = 2'b01;
        mem_gnt  = 1'b1;
        step();
        step();
        idle_inputs();
        #1;
        check("t5 two outstanding", outstanding, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5 cleared", outstanding, 0);
        check("t5 err cleared", err_spurious, 0);
        mem_rvalid = 1'b1;
        #1;
        check("t5 late resp dropped", host_rvalid, 2'b00);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("t5 late resp spurious", err_spurious, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset    = ($urandom_range(0, 99) == 0);
            host_req = NH'($urandom);
            if (m_lock >= 0) host_req[m_lock] = 1'b1;
            for (int h = 0; h < NH; h++) begin
                host_addr[h*AW +: AW]  = $urandom;
                host_be[h*BW +: BW]    = BW'($urandom);
                host_wdata[h*DW +: DW] = $urandom;
                host_wintg[h*IW +: IW] = IW'($urandom);
            end
            host_we    = NH'($urandom);
            mem_gnt    = ($urandom_range(0, 9) < 6);
            mem_rvalid = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4)
                                          : ($urandom_range(0, 29) == 0);
            mem_rdata  = $urandom;
            mem_rintg  = IW'($urandom);
            mem_error  = $urandom_range(0, 1);
        end
        step();
        reset = 1'b0;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
